// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: op codes, common constants, divider FSM states.
// Imported by ex_stage and ex_div; no module keeps its own op encoding.
package ex_stage_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic        Valid     = 1'b1;
    localparam logic        Invalid   = 1'b0;
    localparam logic [31:0] Zero      = 32'h0000_0000;

    localparam logic [5:0] OpNop   = 6'h00;
    localparam logic [5:0] OpOr    = 6'h01;
    localparam logic [5:0] OpAnd   = 6'h02;
    localparam logic [5:0] OpXor   = 6'h03;
    localparam logic [5:0] OpAdd   = 6'h04;
    localparam logic [5:0] OpSub   = 6'h05;
    localparam logic [5:0] OpSubr  = 6'h06;
    localparam logic [5:0] OpLui   = 6'h07;
    localparam logic [5:0] OpSll   = 6'h08;
    localparam logic [5:0] OpSrl   = 6'h09;
    localparam logic [5:0] OpSra   = 6'h0A;
    localparam logic [5:0] OpJ     = 6'h0B;
    localparam logic [5:0] OpJal   = 6'h0C;
    localparam logic [5:0] OpBeq   = 6'h0D;
    localparam logic [5:0] OpBne   = 6'h0E;
    localparam logic [5:0] OpBltz  = 6'h0F;
    localparam logic [5:0] OpBgtz  = 6'h10;
    localparam logic [5:0] OpLw    = 6'h11;
    localparam logic [5:0] OpSw    = 6'h12;
    localparam logic [5:0] OpLl    = 6'h13;
    localparam logic [5:0] OpSc    = 6'h14;
    localparam logic [5:0] OpMult  = 6'h15;
    localparam logic [5:0] OpMultu = 6'h16;
    localparam logic [5:0] OpDiv   = 6'h17;
    localparam logic [5:0] OpDivu  = 6'h18;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    // Ops that never write the destination register regardless of regcWrite.
    function automatic logic op_blocks_write(input logic [5:0] op);
        logic blocks;
        blocks = 1'b0;
        case (op)
            OpSw, OpJ, OpBeq, OpBne, OpBltz, OpBgtz, OpNop,
            OpMult, OpMultu, OpDiv, OpDivu: blocks = 1'b1;
            default:                        blocks = 1'b0;
        endcase
        return blocks;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider: 32 BUSY iterations then one DONE cycle, magnitudes with sign fix-up.
// Only compiled when EX_DIV_EN is defined.
`ifdef EX_DIV_EN
module ex_div
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    div_state_e  state_q, state_d;
    logic [4:0]  count_q;
    logic [31:0] rem_q, quot_q, divisor_q;
    logic        neg_quot_q, neg_rem_q;

    logic [31:0] abs_dividend, abs_divisor;
    logic [32:0] partial;
    logic [33:0] diff;
    logic [31:0] rem_step, quot_step;

    assign abs_dividend = (div_signed && dividend[31]) ? (Zero - dividend) : dividend;
    assign abs_divisor  = (div_signed && divisor[31])  ? (Zero - divisor)  : divisor;

    // One restoring step; quotient bits shift in as dividend bits shift out.
    always_comb begin
        partial = {rem_q, quot_q[31]};
        diff    = {1'b0, partial} - {2'b00, divisor_q};
        if (!diff[33]) begin
            rem_step  = diff[31:0];
            quot_step = {quot_q[30:0], 1'b1};
        end else begin
            rem_step  = partial[31:0];
            quot_step = {quot_q[30:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (count_q == 5'd31) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            count_q    <= 5'd0;
            rem_q      <= Zero;
            quot_q     <= Zero;
            divisor_q  <= Zero;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (state_q == StIdle && start) begin
            count_q    <= 5'd0;
            rem_q      <= Zero;
            quot_q     <= abs_dividend;
            divisor_q  <= abs_divisor;
            neg_quot_q <= div_signed && (dividend[31] ^ divisor[31]);
            neg_rem_q  <= div_signed && dividend[31];
        end else if (state_q == StBusy) begin
            rem_q   <= rem_step;
            quot_q  <= quot_step;
            count_q <= count_q + 5'd1;
        end
    end

    // done marks the last iteration so the caller captures the result on that edge.
    assign busy = (state_q != StIdle);
    assign done = (state_q == StBusy) && (count_q == 5'd31);
    assign quot = neg_quot_q ? (Zero - quot_step) : quot_step;
    assign rem  = neg_rem_q  ? (Zero - rem_step)  : rem_step;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/memory/multiply ops into registered outputs plus HI/LO.
// Define EX_DIV_EN to add the stalling iterative divider (ex_div) for Div/Divu.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [31:0] regaData,
    input  logic [31:0] regbData,
    input  logic        regcWrite,
    input  logic [4:0]  regcAddr,
    input  logic        in_valid,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] regcData_o,
    output logic        regcWrite_o,
    output logic [4:0]  regcAddr_o,
    output logic [5:0]  memOp_o,
    output logic [31:0] memAddr_o,
    output logic [31:0] memData_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic        out_valid_q, regc_write_q;
    logic [31:0] regc_data_q, mem_addr_q, mem_data_q, hi_q, lo_q;
    logic [4:0]  regc_addr_q;
    logic [5:0]  mem_op_q;

    logic        accept, div_start;
    logic [31:0] res_data, res_maddr, res_mdata;
    logic        res_write, hilo_we;
    logic [5:0]  res_memop;
    logic [63:0] hilo_val, mul_s, mul_u;

    assign accept = in_valid && !stall;
    assign mul_s  = $signed({{32{regaData[31]}}, regaData}) *
                    $signed({{32{regbData[31]}}, regbData});
    assign mul_u  = {32'h0, regaData} * {32'h0, regbData};

`ifdef EX_DIV_EN
    logic        div_busy, div_done;
    logic [31:0] div_quot, div_rem;

    // A zero divisor is resolved in one cycle below and never starts the divider.
    assign div_start = accept && ((op == OpDiv) || (op == OpDivu)) && (regbData != Zero);
    assign stall     = div_busy;

    ex_div u_ex_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .div_signed (op == OpDiv),
        .dividend   (regaData),
        .divisor    (regbData),
        .busy       (div_busy),
        .done       (div_done),
        .quot       (div_quot),
        .rem        (div_rem)
    );
`else
    assign div_start = 1'b0;
    assign stall     = 1'b0;
`endif

    always_comb begin
        res_data  = Zero;
        res_write = regcWrite & ~op_blocks_write(op);
        res_memop = op;
        res_maddr = Zero;
        res_mdata = Zero;
        hilo_we   = 1'b0;
        hilo_val  = {Zero, Zero};
        unique case (op)
            OpOr:          res_data = regaData | regbData;
            OpAnd:         res_data = regaData & regbData;
            OpXor:         res_data = regaData ^ regbData;
            OpAdd:         res_data = regaData + regbData;
            OpSub, OpSubr: res_data = regaData - regbData;
            OpLui, OpJal:  res_data = regbData;
            OpSll:         res_data = regbData << regaData[4:0];
            OpSrl:         res_data = regbData >> regaData[4:0];
            OpSra:         res_data = $unsigned($signed(regbData) >>> regaData[4:0]);
            OpLw:          res_maddr = regaData;
            OpLl:          res_maddr = regaData + regbData;
            OpSw: begin
                res_maddr = regaData;
                res_mdata = regbData;
            end
            OpSc: begin
                res_maddr = regaData + regbData;
                res_mdata = regbData;
            end
            OpNop, OpJ, OpBeq, OpBne, OpBltz, OpBgtz: begin
            end
            OpMult: begin
                hilo_we  = 1'b1;
                hilo_val = mul_s;
            end
            OpMultu: begin
                hilo_we  = 1'b1;
                hilo_val = mul_u;
            end
`ifdef EX_DIV_EN
            OpDiv, OpDivu: begin
                if (regbData == Zero) begin
                    hilo_we  = 1'b1;
                    hilo_val = {regaData, 32'hFFFF_FFFF};
                end
            end
`else
            OpDiv, OpDivu: res_memop = OpNop;
`endif
            default: begin
                res_write = 1'b0;
                res_memop = OpNop;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            out_valid_q  <= Invalid;
            regc_data_q  <= Zero;
            regc_write_q <= 1'b0;
            regc_addr_q  <= 5'd0;
            mem_op_q     <= OpNop;
            mem_addr_q   <= Zero;
            mem_data_q   <= Zero;
            hi_q         <= Zero;
            lo_q         <= Zero;
        end else begin
            out_valid_q <= Invalid;
            if (accept) begin
                // A started division reports out_valid only when it finishes.
                out_valid_q  <= div_start ? Invalid : Valid;
                regc_data_q  <= res_data;
                regc_write_q <= res_write;
                regc_addr_q  <= regcAddr;
                mem_op_q     <= res_memop;
                mem_addr_q   <= res_maddr;
                mem_data_q   <= res_mdata;
                if (hilo_we) begin
                    {hi_q, lo_q} <= hilo_val;
                end
            end
`ifdef EX_DIV_EN
            if (div_done) begin
                out_valid_q <= Valid;
                hi_q        <= div_rem;
                lo_q        <= div_quot;
            end
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign regcData_o  = regc_data_q;
    assign regcWrite_o = regc_write_q;
    assign regcAddr_o  = regc_addr_q;
    assign memOp_o     = mem_op_q;
    assign memAddr_o   = mem_addr_q;
    assign memData_o   = mem_data_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed table, multi-cycle divide/reset sequences and
// randomized ops against an arithmetic reference model. Follows EX_DIV_EN like the RTL.
module tb_ex_stage;
    import ex_stage_pkg::*;

`ifdef EX_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic        clk, rst;
    logic [5:0]  op;
    logic [31:0] regaData, regbData;
    logic        regcWrite, in_valid;
    logic [4:0]  regcAddr;
    logic        stall, out_valid, regcWrite_o;
    logic [31:0] regcData_o, memAddr_o, memData_o, hi_o, lo_o;
    logic [4:0]  regcAddr_o;
    logic [5:0]  memOp_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic [5:0]  memop;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } exp_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic [31:0] data;
        logic        exp_we;
        logic [5:0]  memop;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } vec_t;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .regaData    (regaData),
        .regbData    (regbData),
        .regcWrite   (regcWrite),
        .regcAddr    (regcAddr),
        .in_valid    (in_valid),
        .stall       (stall),
        .out_valid   (out_valid),
        .regcData_o  (regcData_o),
        .regcWrite_o (regcWrite_o),
        .regcAddr_o  (regcAddr_o),
        .memOp_o     (memOp_o),
        .memAddr_o   (memAddr_o),
        .memData_o   (memData_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: run exceeded time limit, got no finish, wanted finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic we);
        exp_t e;
        int   sh;
        sh = int'(a[4:0]);
        e  = '{data: 32'h0, we: we, memop: o, maddr: 32'h0, mdata: 32'h0};
        case (o)
            OpOr:          e.data = a | b;
            OpAnd:         e.data = a & b;
            OpXor:         e.data = a ^ b;
            OpAdd:         e.data = a + b;
            OpSub, OpSubr: e.data = a - b;
            OpLui, OpJal:  e.data = b;
            OpSll:         e.data = b << sh;
            OpSrl:         e.data = b >> sh;
            OpSra:         e.data = b[31] ? ~((~b) >> sh) : (b >> sh);
            OpLw:          e.maddr = a;
            OpLl:          e.maddr = a + b;
            OpSw:    begin e.maddr = a; e.mdata = b; e.we = 1'b0; end
            OpSc:    begin e.maddr = a + b; e.mdata = b; end
            OpNop, OpJ, OpBeq, OpBne, OpBltz, OpBgtz, OpMult, OpMultu: e.we = 1'b0;
            OpDiv, OpDivu: begin
                e.we = 1'b0;
                if (!DivEn) e.memop = OpNop;
            end
            default: begin e.we = 1'b0; e.memop = OpNop; end
        endcase
        return e;
    endfunction

    task automatic model_hilo(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (o == OpMult) begin
            sp = sa * sb;
            {m_hi, m_lo} = sp;
        end else if (o == OpMultu) begin
            up = ua * ub;
            {m_hi, m_lo} = up;
        end else if (DivEn && (o == OpDiv || o == OpDivu)) begin
            if (b == 32'h0) begin
                m_lo = 32'hFFFF_FFFF;
                m_hi = a;
            end else if (o == OpDiv) begin
                sq = sa / sb;
                sr = sa % sb;
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end else begin
                up   = ua / ub;
                m_lo = up[31:0];
                up   = ua % ub;
                m_hi = up[31:0];
            end
        end
    endtask

    task automatic issue(input string name, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic we, input logic [4:0] addr,
                         input exp_t e, input int exp_stall);
        int stalls;
        int cyc;
        stalls = 0;
        @(negedge clk);
        op = o; regaData = a; regbData = b; regcWrite = we; regcAddr = addr; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (stall) stalls++;
            if (out_valid) break;
            @(negedge clk);
        end
        check({name, ":out_valid"}, out_valid, 1);
        check({name, ":data"}, regcData_o, e.data);
        check({name, ":we"}, regcWrite_o, e.we);
        check({name, ":addr"}, regcAddr_o, addr);
        check({name, ":memop"}, memOp_o, e.memop);
        check({name, ":maddr"}, memAddr_o, e.maddr);
        check({name, ":mdata"}, memData_o, e.mdata);
        check({name, ":hi"}, hi_o, m_hi);
        check({name, ":lo"}, lo_o, m_lo);
        check({name, ":stall_cycles"}, stalls, exp_stall);
        @(negedge clk);
        check({name, ":pulse_end"}, {stall, out_valid}, 0);
    endtask

    task automatic run_model(input string name, input logic [5:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic we, input logic [4:0] addr);
        int exp_stall;
        exp_stall = (DivEn && (o == OpDiv || o == OpDivu) && b != 32'h0) ? 33 : 0;
        model_hilo(o, a, b);
        issue(name, o, a, b, we, addr, model(o, a, b, we), exp_stall);
    endtask

    vec_t        vecs[$];
    logic [5:0]  known_ops [25];
    logic [5:0]  r_op;
    logic [31:0] r_a, r_b;
    exp_t        e;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = OpNop; regaData = 0; regbData = 0;
        regcWrite = 1'b0; regcAddr = 5'd0;
        m_hi = 32'h0; m_lo = 32'h0;
        known_ops = '{OpNop, OpOr, OpAnd, OpXor, OpAdd, OpSub, OpSubr, OpLui, OpSll, OpSrl,
                      OpSra, OpJ, OpJal, OpBeq, OpBne, OpBltz, OpBgtz, OpLw, OpSw, OpLl,
                      OpSc, OpMult, OpMultu, OpDiv, OpDivu};

        repeat (3) @(negedge clk);
        check("reset:out_valid", out_valid, 0);
        check("reset:stall", stall, 0);
        check("reset:data", regcData_o, 0);
        check("reset:we", regcWrite_o, 0);
        check("reset:addr", regcAddr_o, 0);
        check("reset:memop", memOp_o, OpNop);
        check("reset:maddr", memAddr_o, 0);
        check("reset:mdata", memData_o, 0);
        check("reset:hilo", {hi_o, lo_o}, 0);
        rst = 1'b0;

        vecs.push_back('{"add_ovf", OpAdd, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 1'b1, OpAdd, 0, 0});
        vecs.push_back('{"sra", OpSra, 32'd4, 32'hF000_0000, 1'b1, 32'hFF00_0000, 1'b1, OpSra, 0, 0});
        vecs.push_back('{"srl", OpSrl, 32'd4, 32'hF000_0000, 1'b1, 32'h0F00_0000, 1'b1, OpSrl, 0, 0});
        vecs.push_back('{"sll", OpSll, 32'd31, 32'h3, 1'b1, 32'h8000_0000, 1'b1, OpSll, 0, 0});
        vecs.push_back('{"sub_wrap", OpSub, 32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF, 1'b1, OpSub, 0, 0});
        vecs.push_back('{"subr", OpSubr, 32'd10, 32'd3, 1'b1, 32'd7, 1'b1, OpSubr, 0, 0});
        vecs.push_back('{"lui", OpLui, 32'h55, 32'h1234_0000, 1'b1, 32'h1234_0000, 1'b1, OpLui, 0, 0});
        vecs.push_back('{"or", OpOr, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1, 32'hF0F0_0F0F, 1'b1, OpOr, 0, 0});
        vecs.push_back('{"and", OpAnd, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 32'h0F00_0F00, 1'b0, OpAnd, 0, 0});
        vecs.push_back('{"xor", OpXor, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 32'h00FF_FF00, 1'b1, OpXor, 0, 0});
        vecs.push_back('{"jal", OpJal, 32'h0, 32'h0040_0008, 1'b1, 32'h0040_0008, 1'b1, OpJal, 0, 0});
        vecs.push_back('{"sw", OpSw, 32'h1000, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, OpSw, 32'h1000, 32'hDEAD_BEEF});
        vecs.push_back('{"sc", OpSc, 32'h1000, 32'h4, 1'b1, 0, 1'b1, OpSc, 32'h1004, 32'h4});
        vecs.push_back('{"ll", OpLl, 32'h2000, 32'h8, 1'b1, 0, 1'b1, OpLl, 32'h2008, 0});
        vecs.push_back('{"lw", OpLw, 32'h3000, 32'h5, 1'b1, 0, 1'b1, OpLw, 32'h3000, 0});
        vecs.push_back('{"beq", OpBeq, 32'h1, 32'h1, 1'b1, 0, 1'b0, OpBeq, 0, 0});
        vecs.push_back('{"unknown", 6'h3F, 32'h1, 32'h2, 1'b1, 0, 1'b0, OpNop, 0, 0});

        foreach (vecs[i]) begin
            e = '{data: vecs[i].data, we: vecs[i].exp_we, memop: vecs[i].memop,
                  maddr: vecs[i].maddr, mdata: vecs[i].mdata};
            issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].we, 5'(i), e, 0);
        end

        run_model("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd5, 1'b1, 5'd3);
        check("mult_neg:hi_const", hi_o, 32'hFFFF_FFFF);
        check("mult_neg:lo_const", lo_o, 32'hFFFF_FFF1);
        run_model("multu_big", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd4);

        run_model("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd5);
`ifdef EX_DIV_EN
        check("div_m7_2:lo_const", lo_o, 32'hFFFF_FFFD);
        check("div_m7_2:hi_const", hi_o, 32'hFFFF_FFFF);
`endif
        run_model("divu_by0", OpDivu, 32'd9, 32'd0, 1'b1, 5'd6);
`ifdef EX_DIV_EN
        check("divu_by0:lo_const", lo_o, 32'hFFFF_FFFF);
        check("divu_by0:hi_const", hi_o, 32'd9);
`endif
        run_model("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 1'b1, 5'd7);
        run_model("div_min_m1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd8);
        run_model("divu_max", OpDivu, 32'hFFFF_FFFF, 32'd3, 1'b1, 5'd9);

`ifdef EX_DIV_EN
        // Next op is held on the inputs during the stall and must wait until after DONE.
        @(negedge clk);
        op = OpDivu; regaData = 32'd100; regbData = 32'd7; regcWrite = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        op = OpAdd; regaData = 32'd5; regbData = 32'd6; regcAddr = 5'd11;
        for (int cyc = 0; cyc < 40 && !out_valid; cyc++) @(negedge clk);
        check("hold:div_valid", out_valid, 1);
        check("hold:div_lo", lo_o, 32'd14);
        check("hold:div_hi", hi_o, 32'd2);
        check("hold:add_not_taken", regcData_o, 32'd0);
        @(negedge clk);
        check("hold:gap", {stall, out_valid}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("hold:add_valid", out_valid, 1);
        check("hold:add_data", regcData_o, 32'd11);
        check("hold:add_addr", regcAddr_o, 5'd11);
        @(negedge clk);
        check("hold:add_pulse", out_valid, 0);
        m_hi = 32'd2; m_lo = 32'd14;
`endif

        // Reset landing in the middle of a division.
        run_model("mult_pre_rst", OpMult, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5'd12);
        @(negedge clk);
        op = OpDiv; regaData = 32'd100; regbData = 32'd3; regcWrite = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_div:stall", stall, 0);
        check("rst_div:out_valid", out_valid, 0);
        check("rst_div:hi", hi_o, 0);
        check("rst_div:lo", lo_o, 0);
        check("rst_div:memop", memOp_o, OpNop);
        m_hi = 32'h0; m_lo = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_div:stays_idle", {stall, out_valid}, 0);
        run_model("rst_div:add", OpAdd, 32'd40, 32'd2, 1'b1, 5'd13);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) r_op = 6'($urandom_range(25, 63));
            else r_op = known_ops[$urandom_range(0, 24)];
            r_a = $urandom;
            r_b = $urandom;
            if ((r_op == OpDiv || r_op == OpDivu) && $urandom_range(0, 2) == 0)
                r_b = 32'($urandom_range(0, 9));
            run_model($sformatf("rand%0d_op%0h", i, r_op), r_op, r_a, r_b, 1'($urandom),
                      5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high (`RstEnable).
REQ-003 SHALL have ports:
- op  in  6  decoded operation from decode stage.
- regaData  in  32  operand A; holds shamt for Sll/Srl/Sra and the effective address for Lw/Sw.
- regbData  in  32  operand B or immediate; holds npc for Jal.
REQ-004 SHALL have ports: regcWrite  in  1, regcAddr  in  5  destination write enable and address.
REQ-005 SHALL have ports: in_valid  in  1, stall  out  1  upstream holds all inputs while stall=1.
REQ-006 SHALL have ports:
- out_valid  out  1
- regcData_o  out  32
- regcWrite_o  out  1
- regcAddr_o  out  5
- memOp_o  out  6
- memAddr_o  out  32
- memData_o  out  32
REQ-007 SHALL have ports: hi_o  out  32, lo_o  out  32  HI/LO architectural registers.

Function
REQ-010 SHALL register every accepted op (in_valid=1, stall=0) into output registers after 1 cycle; out_valid=1 for exactly that cycle.
REQ-011 SHALL compute regcData as follows:
- Or/And/Xor/Add: A op B, 32-bit wrap.
- Subr/Sub: A-B, 32-bit wrap.
- Lui: B.
- Sll/Srl/Sra: B shifted by A[4:0]; Sra sign-fills.
- Jal: B.
REQ-012 SHALL handle memory ops:
- Lw/Ll/Sw/Sc: memAddr_o = A (Ll/Sc: A+B).
- Sw/Sc: memData_o = operand B register value, passed through on regbData.
- memOp_o = op.
REQ-013 SHALL force regcWrite_o=0 for Sw, J, Beq, Bne, Bltz, Bgtz, Nop, Mult, Multu, Div, Divu; all other ops pass regcWrite through.
REQ-014 SHALL complete Mult (signed) / Multu (unsigned) in 1 cycle: {hi,lo} = 64-bit product.
REQ-015 SHALL implement Div/Divu as an iterative restoring divider of 32 iterations plus 1 finish cycle:
- stall=1 from the cycle after acceptance until the finish cycle.
- On finish: lo=quotient, hi=remainder, out_valid=1.
REQ-016 SHALL, for signed Div, divide magnitudes; quotient negative iff signs differ; remainder takes dividend sign.
REQ-017 SHALL, for divide-by-zero, take 1 cycle with no stall: lo=32'hFFFFFFFF, hi=dividend.
REQ-018 SHALL use divider FSM states IDLE -> BUSY (count 0..31) -> DONE -> IDLE; DONE returns to IDLE unconditionally.
REQ-019 SHALL ignore in_valid while stall=1; the next op is accepted in the cycle after DONE.
REQ-020 SHALL, for unknown op, output Nop with regcWrite_o=0; out_valid still asserts.

Reset
REQ-030 SHALL, on rst=1, clear out_valid, stall, regcWrite_o, regcData_o, regcAddr_o, memAddr_o, memData_o, hi_o and lo_o to 0, set memOp_o=`Nop, and force the FSM to IDLE.
REQ-031 SHALL, on rst mid-division, abort the division; HI/LO keep no partial result (0).

Configuration
REQ-040 SHALL, with EX_DIV_EN defined, implement REQ-015..REQ-018.
REQ-041 SHALL, without EX_DIV_EN, treat Div/Divu as Nop: hi/lo unchanged, stall never asserted, divider logic absent.

Structure
REQ-050 SHALL take op codes, `Zero, `Valid/`Invalid and `RstEnable from the shared define.v package; no local op encodings.
REQ-051 SHALL place the iterative divider in sub-module ex_div (start, signed, dividend, divisor -> busy, done, quot, rem).

Verification
REQ-060 SHALL pass: Add A=32'h7FFFFFFF, B=1 -> next cycle regcData_o=32'h80000000, out_valid=1.
REQ-061 SHALL pass: Sra A=4, B=32'hF0000000 -> regcData_o=32'hFF000000.
REQ-062 SHALL pass: Mult A=-3, B=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; regcWrite_o=0.
REQ-063 SHALL pass: Div A=-7, B=2 -> stall high 33 cycles; then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-064 SHALL pass: Divu A=9, B=0 -> no stall; lo=32'hFFFFFFFF, hi=9.
REQ-065 SHALL pass: rst asserted at divide iteration 10 -> next cycle stall=0, hi=lo=0, FSM IDLE; a following Add is accepted normally.
